systolic_drain: RTL and testbench

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

---
 rtl/systolic_drain.sv | 188 ++++++++++++++++++
 tb/tb_systolic_drain.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// -----------------------------------------------------------------------------
// systolic_drain
//   Sequencer for an N x N systolic multiply array. A run clears the array,
//   keeps the operand feeder enabled for k_len cycles, waits for the wavefront
//   to fill and drain, snapshots all N*N accumulators into a shadow bank and
//   streams them out one cell per beat over a valid/ready handshake.
//
// Ports
//   sys_clk    in   sole clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   begin a run (sampled only when idle)
//   k_len      in   number of inner-product terms (sampled with start)
//   sum_in     in   flattened accumulators, cell i at sum_in[W*i +: W]
//   arr_clr    out  one-cycle synchronous clear to the array
//   feed_en    out  feeder must present operands
//   busy       out  high whenever a run is in progress
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the beat
//   out_data   out  shadow copy of the current cell
//   out_idx    out  index of the current cell
//   out_last   out  marks the beat for cell N*N-1
//   done       out  one-cycle pulse at run completion
// -----------------------------------------------------------------------------
module systolic_drain #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int CW = 8,
   localparam int IW = ((N * N) > 1) ? $clog2(N * N) : 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               start,
   input  logic [CW-1:0]      k_len,
   input  logic [N*N*W-1:0]   sum_in,
   output logic               arr_clr,
   output logic               feed_en,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_data,
   output logic [IW-1:0]      out_idx,
   output logic               out_last,
   output logic               done
);

   localparam int CELLS = N * N;
   // Wide enough for k_len max plus the 2N-2 fill/drain tail without wrap.
   localparam int CNTW = CW + $clog2(2 * N) + 1;
   localparam logic [CNTW-1:0] FILL_DRAIN = CNTW'(2 * N - 2);
   localparam logic [IW-1:0]   LAST_IDX   = IW'(CELLS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      COMPUTE = 3'd2,
      CAPTURE = 3'd3,
      STREAM  = 3'd4,
      FIN     = 3'd5
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   k_len_r;
   logic [CNTW-1:0] cnt_r;
   logic [W-1:0]    shadow_r [CELLS];

   logic            arr_clr_r;
   logic            feed_en_r;
   logic            busy_r;
   logic            out_valid_r;
   logic [W-1:0]    out_data_r;
   logic [IW-1:0]   out_idx_r;
   logic            out_last_r;
   logic            done_r;

   logic [CNTW-1:0] k_ext_s;
   logic [CNTW-1:0] compute_len_s;
   logic [CNTW-1:0] cnt_next_s;
   logic [IW-1:0]   idx_next_s;

   // Derived counts: COMPUTE length and next counter / beat index.
   always_comb begin
      k_ext_s       = CNTW'(k_len_r);
      compute_len_s = k_ext_s + FILL_DRAIN;
      cnt_next_s    = cnt_r + CNTW'(1'b1);
      idx_next_s    = out_idx_r + IW'(1'b1);
   end

   // Run sequencer with all outputs registered.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= IDLE;
         k_len_r     <= '0;
         cnt_r       <= '0;
         arr_clr_r   <= 1'b0;
         feed_en_r   <= 1'b0;
         busy_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_idx_r   <= '0;
         out_last_r  <= 1'b0;
         done_r      <= 1'b0;
         for (int i = 0; i < CELLS; i++) begin
            shadow_r[i] <= '0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  k_len_r   <= k_len;
                  cnt_r     <= '0;
                  arr_clr_r <= 1'b1;
                  busy_r    <= 1'b1;
                  state_r   <= CLEAR;
               end
            end
            CLEAR: begin
               arr_clr_r <= 1'b0;
               cnt_r     <= '0;
               // Only a 1x1 array with k_len=0 has an empty compute phase.
               if (compute_len_s == '0) begin
                  state_r <= CAPTURE;
               end else begin
                  feed_en_r <= (k_len_r != '0);
                  state_r   <= COMPUTE;
               end
            end
            COMPUTE: begin
               cnt_r     <= cnt_next_s;
               // Feeder stays on while the cycle about to start is < k_len.
               feed_en_r <= (cnt_next_s < k_ext_s);
               if (cnt_next_s == compute_len_s) begin
                  feed_en_r <= 1'b0;
                  state_r   <= CAPTURE;
               end
            end
            CAPTURE: begin
               for (int i = 0; i < CELLS; i++) begin
                  shadow_r[i] <= sum_in[W*i +: W];
               end
               // Shadow is written on this same edge, so beat 0 comes from sum_in.
               out_data_r  <= sum_in[W-1:0];
               out_idx_r   <= '0;
               out_last_r  <= (LAST_IDX == '0);
               out_valid_r <= 1'b1;
               state_r     <= STREAM;
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_last_r) begin
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                     done_r      <= 1'b1;
                     state_r     <= FIN;
                  end else begin
                     out_idx_r  <= idx_next_s;
                     out_data_r <= shadow_r[idx_next_s];
                     out_last_r <= (idx_next_s == LAST_IDX);
                  end
               end
            end
            FIN: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               arr_clr_r   <= 1'b0;
               feed_en_r   <= 1'b0;
               busy_r      <= 1'b0;
               out_valid_r <= 1'b0;
               out_last_r  <= 1'b0;
               done_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign arr_clr   = arr_clr_r;
   assign feed_en   = feed_en_r;
   assign busy      = busy_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_idx   = out_idx_r;
   assign out_last  = out_last_r;
   assign done      = done_r;

endmodule

// File: tb/tb_systolic_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_drain
//   Randomised bench for systolic_drain (N=4, W=8, CW=8). The driver issues
//   runs and pushes the expected beats into a scoreboard queue; a monitor on
//   the falling edge checks run timing from k_len arithmetic and pops/compares
//   beats whenever the DUT transfers one.
// -----------------------------------------------------------------------------
module tb_systolic_drain;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int CW    = 8;
   localparam int CELLS = N * N;
   localparam int IW    = 4;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   logic               sys_clk   = 1'b0;
   logic               sys_rst_n = 1'b0;
   logic               start     = 1'b0;
   logic [CW-1:0]      k_len     = '0;
   logic [N*N*W-1:0]   sum_in    = '0;
   logic               out_ready = 1'b0;
   logic               arr_clr;
   logic               feed_en;
   logic               busy;
   logic               out_valid;
   logic [W-1:0]       out_data;
   logic [IW-1:0]      out_idx;
   logic               out_last;
   logic               done;

   int    n_checks  = 0;
   int    n_fail    = 0;
   beat_t sb_q[$];
   int    exp_k_q[$];
   int    rdy_mode  = 2;
   int    rdy_phase = 0;
   int    done_seen = 0;
   int    runs_done = 0;

   systolic_drain #(.N(N), .W(W), .CW(CW)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (start),
      .k_len     (k_len),
      .sum_in    (sum_in),
      .arr_clr   (arr_clr),
      .feed_en   (feed_en),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready, driven just after the rising edge so the monitor sees it settled.
   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
               out_ready = (rdy_phase == 0);
               rdy_phase = (rdy_phase + 1) % 3;
            end
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: phase 0 idle, 1 clear/compute/capture, 2 stream, 3 fin.
   int phase = 0;
   int cyc   = 0;
   int cur_k = 0;
   int cur_c = 0;
   initial begin
      beat_t b;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            phase = 0;
         end else begin
            if (phase == 0 && arr_clr) begin
               if (exp_k_q.size() == 0) begin
                  chk("unexpected_run_start", 32'd1, 32'd0);
               end else begin
                  cur_k = exp_k_q.pop_front();
                  cur_c = cur_k + 2 * N - 2;
                  cyc   = 0;
                  phase = 1;
               end
            end
            if (phase == 0) begin
               chk("idle_busy", busy, 0);
               chk("idle_valid", out_valid, 0);
               chk("idle_feed_en", feed_en, 0);
               chk("idle_done", done, 0);
            end else if (phase == 1) begin
               chk("arr_clr_timing", arr_clr, (cyc == 0));
               chk("feed_en_timing", feed_en, (cyc >= 1 && cyc <= cur_k));
               chk("first_valid_timing", out_valid, (cyc == cur_c + 2));
               chk("run_busy", busy, 1);
               chk("run_done_early", done, 0);
               if (cyc == cur_c + 2) phase = 2;
               cyc++;
            end else if (phase == 3) begin
               chk("done_after_last", done, 1);
               chk("fin_valid", out_valid, 0);
               chk("fin_busy", busy, 1);
               if (done) done_seen++;
               phase = 0;
            end
            if (phase == 2) begin
               chk("stream_busy", busy, 1);
               chk("stream_feed_en", feed_en, 0);
               chk("stream_arr_clr", arr_clr, 0);
               chk("stream_done", done, 0);
               chk("stream_valid", out_valid, 1);
               if (sb_q.size() == 0) begin
                  chk("beat_without_expectation", 32'd1, 32'd0);
               end else if (out_valid) begin
                  b = sb_q[0];
                  chk("beat_data", out_data, b.data);
                  chk("beat_idx", out_idx, b.idx);
                  chk("beat_last", out_last, b.last);
                  if (out_ready) begin
                     void'(sb_q.pop_front());
                     if (b.last) phase = 3;
                  end
               end
            end
         end
      end
   end

   task automatic make_pattern(input int pat, output logic [W-1:0] p [CELLS]);
      for (int i = 0; i < CELLS; i++) begin
         if (pat == 0) p[i] = W'(i + 1);
         else          p[i] = W'($urandom_range(0, 255));
      end
      if (pat != 0) p[3] = 8'h80;
   endtask

   task automatic issue(input int k, input logic [W-1:0] p [CELLS]);
      beat_t b;
      for (int i = 0; i < CELLS; i++) begin
         sum_in[W*i +: W] = p[i];
         b.data = p[i];
         b.idx  = IW'(i);
         b.last = (i == CELLS - 1);
         sb_q.push_back(b);
      end
      exp_k_q.push_back(k);
      k_len = CW'(k);
      start = 1'b1;
   endtask

   task automatic run_one(input int k, input int pat, input int mode,
                          input bit snap, input bit pulse_compute, input bit pulse_fin);
      logic [W-1:0] p [CELLS];
      bit got_done;
      bit snapped;
      make_pattern(pat, p);
      rdy_mode  = mode;
      rdy_phase = 0;
      got_done  = 1'b0;
      snapped   = 1'b0;
      @(negedge sys_clk);
      issue(k, p);
      @(negedge sys_clk);
      start = 1'b0;
      k_len = CW'($urandom_range(0, 255));
      if (pulse_compute) begin
         @(negedge sys_clk);
         start = 1'b1;
         k_len = 8'd9;
         @(negedge sys_clk);
         start = 1'b0;
      end
      for (int c = 0; c < 3000; c++) begin
         @(negedge sys_clk);
         if (snap && out_valid && !snapped) begin
            sum_in  = {CELLS{8'h7F}};
            snapped = 1'b1;
         end
         if (done) begin
            got_done = 1'b1;
            if (pulse_fin) begin
               start = 1'b1;
               k_len = 8'd2;
            end
            break;
         end
      end
      chk("run_completes", got_done, 1);
      if (got_done) runs_done++;
      @(negedge sys_clk);
      start = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("post_run_idle", busy, 0);
      chk("all_beats_delivered", sb_q.size(), 0);
      chk("done_pulse_count", done_seen, runs_done);
   endtask

   initial begin
      logic [W-1:0] p [CELLS];
      bit found;

      // Reset with random inputs: everything held at zero.
      rdy_mode = 2;
      for (int r = 0; r < 4; r++) begin
         @(negedge sys_clk);
         start  = 1'($urandom_range(0, 1));
         k_len  = CW'($urandom_range(0, 255));
         sum_in = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk("rst_arr_clr", arr_clr, 0);
         chk("rst_feed_en", feed_en, 0);
         chk("rst_busy", busy, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_data", out_data, 0);
         chk("rst_idx", out_idx, 0);
         chk("rst_last", out_last, 0);
         chk("rst_done", done, 0);
      end
      @(negedge sys_clk);
      start     = 1'b0;
      sys_rst_n = 1'b1;

      run_one(3, 0, 0, 1'b0, 1'b0, 1'b0);
      run_one(5, 0, 0, 1'b0, 1'b0, 1'b0);
      run_one(5, 0, 1, 1'b0, 1'b0, 1'b0);
      run_one(4, 1, 0, 1'b1, 1'b0, 1'b0);
      run_one(0, 1, 2, 1'b0, 1'b0, 1'b0);
      run_one(255, 0, 0, 1'b0, 1'b1, 1'b1);

      // Abort in the middle of the stream at beat 7.
      make_pattern(0, p);
      rdy_mode = 0;
      @(negedge sys_clk);
      issue(2, p);
      @(negedge sys_clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge sys_clk);
         if (out_valid && out_idx == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      chk("abort_reached_idx7", found, 1);
      #1 sys_rst_n = 1'b0;
      #1;
      chk("abort_valid_async", out_valid, 0);
      chk("abort_idx", out_idx, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      sb_q.delete();
      exp_k_q.delete();
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (8) @(negedge sys_clk);
      chk("abort_no_done", done_seen, runs_done);
      chk("abort_idle", busy, 0);

      run_one(1, 1, 1, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) begin
         run_one($urandom_range(0, 20), $urandom_range(0, 1), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
